spi_master_multi: RTL and testbench
===================================

// Module: spi_master_multi
// PURPOSE
//  Second-generation SPI master for the W5500 / peripheral path. Moves len words between a TX FIFO
//  and an RX FIFO over SPI, using the work/op/len/busy command handshake from the control FSM.
//  Adds run-time clock divider, all four CPOL/CPHA modes, parametrised word width and CS_NUM chip
//  selects, stall-on-empty/full flow control and a done pulse.
// PARAMETERS
//  DATA    8   bits per SPI word, shifted MSB first
//  CS_NUM  2   number of active-low chip selects
//  DIV_W   8   width of cfg_div
//  LEN_W   16  width of len (words per burst)
// PORTS
//  clk      in   1            system clock
//  rst      in   1            asynchronous active-high reset
//  work     in   1            start pulse, sampled only in IDLE
//  op       in   1            0 = write-only (RX discarded), 1 = write/read (RX pushed)
//  len      in   LEN_W        words in burst, latched on work
//  cfg_div  in   DIV_W        half-period of sclk = cfg_div+1 clk cycles, latched on work
//  cfg_cpol in   1            sclk idle level, latched on work
//  cfg_cpha in   1            0 = sample on leading edge, 1 = sample on trailing edge, latched on work
//  cfg_cs   in   $clog2(CS_NUM) chip-select index, latched on work; index >= CS_NUM selects none
//  rdata    in   DATA         TX FIFO data; valid the cycle after rd
//  rd       out  1            TX FIFO pop, one cycle wide
//  empty    in   1            TX FIFO empty
//  wdata    out  DATA         RX FIFO data
//  wr       out  1            RX FIFO push, one cycle wide
//  full     in   1            RX FIFO full
//  busy     out  1            high from the cycle after work until done
//  done     out  1            one-cycle pulse when the burst completes
//  sclk     out  1            SPI clock
//  mosi     out  1            SPI data out
//  miso     in   1            SPI data in
//  scsn     out  CS_NUM       active-low chip selects
// BEHAVIOUR
//  Reset values: rd=wr=busy=done=0, wdata=0, mosi=0, sclk=0, scsn=all 1, latched cfg=0, FSM=IDLE.
//  Reset is asynchronous and overrides everything mid-burst: CS releases immediately, no done pulse.
//  Half-period timer: reloads to cfg_div and ticks when it reaches 0. cfg_div=0 gives sclk=clk/2.
//  FSM:
//   IDLE: on work, latch op, len, cfg_* and go to START; busy=1 next cycle. work while busy is ignored.
//   len=0: no CS, no sclk; done pulses 1 cycle after work; busy falls with done.
//   START: set sclk=cpol, assert scsn[cs], go to LOAD. CS setup before first edge >= one half-period.
//   LOAD: if !empty, pulse rd and go to FETCH. If empty, stay here (stall) with sclk idle and CS held.
//   FETCH: capture rdata into the shift register. CPHA=0: drive MSB on mosi now. Go to SHIFT.
//   SHIFT: 2*DATA sclk edges, one per tick.
//    CPHA=0: sample miso on odd edges, shift mosi on even edges (except the last).
//    CPHA=1: shift mosi on odd edges, sample miso on even edges.
//    After the final edge sclk is back at cpol. Go to STORE.
//   STORE: if op=1 and full, stall here. If op=1 and !full, set wdata and pulse wr.
//    Decrement the word count; go to LOAD if words remain, else FINISH.
//   FINISH: hold CS for one half-period, deassert scsn, pulse done, clear busy, go to IDLE.
//  Burst: CS stays asserted across all words. Inter-word gap is sclk idle for >= 3 clk cycles
//   plus any stall time.
//  Word counter: LEN_W bits, no wrap. len=2^LEN_W-1 is legal.
//  Simultaneous rd and wr are permitted. rd and wr never repeat while a stall is in progress.
//  mosi holds its last bit between words and is 0 in IDLE.
// TESTING
//  T1 mode0, div=1, op=1, len=1, TX=0xA5, miso loopback: 8 sclk periods of 4 clk; RX=0xA5; done x1.
//  T2 every mode (cpol/cpha in 00,01,10,11) with a slave model, len=3, TX 0x81,0x3C,0xFF:
//     RX matches slave data; sclk idles at cpol; scsn[0] low throughout, single assertion.
//  T3 op=0, len=4: 4 rd pulses, no wr pulses; cfg_cs=1 drives scsn=2'b01 only.
//  T4 TX empty after word 1 for 50 cycles: sclk frozen, CS held; burst resumes and completes.
//     RX full before word 2 store: wr withheld until full falls; no data lost.
//  T5 len=0: done one cycle after work; scsn stays all 1; no rd. work during busy: ignored.
//  T6 rst asserted mid-SHIFT: same cycle scsn=all 1, sclk=0, busy=0; next work runs a clean burst.

Source files
------------

// File: rtl/spi_master_multi.sv
// spi_master_multi
//   SPI master that moves a burst of len words from a TX FIFO to the SPI
//   bus and, for op=1, pushes the received words into an RX FIFO.
//   The clock divider, CPOL/CPHA, chip-select index, op and len are all
//   latched on work and stay fixed for the whole burst.
//
// Handshake:
//   - work is a start pulse. It is only accepted in IDLE.
//   - busy is high from the cycle after an accepted work until done.
//   - done is a one-cycle pulse. busy falls in the same cycle that done rises.
//   - rd pops the TX FIFO for one cycle. rdata is valid in the following cycle.
//   - wr pushes wdata into the RX FIFO for one cycle.
//   - empty and full stall the engine. Neither rd nor wr repeats during a stall.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   work, op, len       command interface; busy/done status
//   cfg_div/cpol/cpha   sclk half-period (cfg_div+1 clk) and SPI mode
//   cfg_cs              chip-select index; an index >= CS_NUM selects no device
//   rdata, rd, empty    TX FIFO read side
//   wdata, wr, full     RX FIFO write side
//   sclk, mosi, miso    SPI bus
//   scsn                active-low chip selects
//   dbg_state           current FSM state, for observation only
module spi_master_multi #(
  parameter int DATA   = 8,
  parameter int CS_NUM = 2,
  parameter int DIV_W  = 8,
  parameter int LEN_W  = 16,
  parameter int CS_W   = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              work,
  input  logic              op,
  input  logic [LEN_W-1:0]  len,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_cpol,
  input  logic              cfg_cpha,
  input  logic [CS_W-1:0]   cfg_cs,
  input  logic [DATA-1:0]   rdata,
  output logic              rd,
  input  logic              empty,
  output logic [DATA-1:0]   wdata,
  output logic              wr,
  input  logic              full,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [CS_NUM-1:0] scsn,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_LOAD, S_FETCH, S_SHIFT, S_STORE, S_FINISH
  } state_t;

  localparam int EC_W = $clog2(2 * DATA);
  localparam logic [EC_W-1:0] LAST_EDGE = EC_W'(2 * DATA - 1);

  state_t              state_q, state_d;
  logic                op_q, op_d, cpol_q, cpol_d, cpha_q, cpha_d;
  logic [DIV_W-1:0]    div_q, div_d, tmr_q, tmr_d;
  logic [CS_W-1:0]     cs_q, cs_d;
  logic [LEN_W-1:0]    words_q, words_d;
  logic [EC_W-1:0]     ecnt_q, ecnt_d;
  logic [DATA-1:0]     tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, wdata_q, wdata_d;
  logic                fetch_ph_q, fetch_ph_d;
  logic                rd_q, rd_d, wr_q, wr_d, busy_q, busy_d, done_q, done_d;
  logic                sclk_q, sclk_d, mosi_q, mosi_d;
  logic [CS_NUM-1:0]   scsn_q, scsn_d;

  // Edges are numbered from 1. The count of edges already made is ecnt_q,
  // so the current edge is odd when ecnt_q is even. Odd edges sample for
  // CPHA=0 and even edges sample for CPHA=1. The remaining edges drive
  // mosi, except the last edge of a CPHA=0 word.
  logic edge_odd, edge_last, do_sample, do_drive;
  assign edge_odd  = ~ecnt_q[0];
  assign edge_last = (ecnt_q == LAST_EDGE);
  assign do_sample = edge_odd ^ cpha_q;
  assign do_drive  = ~do_sample & ~edge_last;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    div_d      = div_q;
    tmr_d      = tmr_q;
    cs_d       = cs_q;
    words_d    = words_q;
    ecnt_d     = ecnt_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    wdata_d    = wdata_q;
    fetch_ph_d = fetch_ph_q;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    done_d     = 1'b0;
    busy_d     = busy_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    scsn_d     = scsn_q;

    case (state_q)
      S_IDLE: begin
        mosi_d = 1'b0;
        if (work) begin
          op_d    = op;
          div_d   = cfg_div;
          cpol_d  = cfg_cpol;
          cpha_d  = cfg_cpha;
          cs_d    = cfg_cs;
          words_d = len;
          if (len == '0) begin
            // An empty burst completes at once, with no CS and no sclk.
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            // Move sclk to its idle level before CS falls. The slave then
            // never sees a level change while it is selected.
            sclk_d  = cfg_cpol;
            state_d = S_START;
          end
        end
      end

      S_START: begin
        sclk_d = cpol_q;
        for (int i = 0; i < CS_NUM; i++) begin
          scsn_d[i] = (cs_q == CS_W'(i)) ? 1'b0 : 1'b1;
        end
        state_d = S_LOAD;
      end

      S_LOAD: begin
        if (!empty) begin
          rd_d       = 1'b1;
          fetch_ph_d = 1'b0;
          state_d    = S_FETCH;
        end
      end

      S_FETCH: begin
        // The first cycle is the pop cycle. rdata is valid in the second.
        if (!fetch_ph_q) begin
          fetch_ph_d = 1'b1;
        end else begin
          if (!cpha_q) begin
            mosi_d  = rdata[DATA-1];
            tx_sr_d = {rdata[DATA-2:0], 1'b0};
          end else begin
            tx_sr_d = rdata;
          end
          ecnt_d  = '0;
          // A full half-period passes before the first edge. This gives
          // the CS setup time.
          tmr_d   = div_q;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - DIV_W'(1);
        end else begin
          tmr_d  = div_q;
          sclk_d = ~sclk_q;
          ecnt_d = ecnt_q + EC_W'(1);
          if (do_sample) rx_sr_d = {rx_sr_q[DATA-2:0], miso};
          if (do_drive) begin
            mosi_d  = tx_sr_q[DATA-1];
            tx_sr_d = {tx_sr_q[DATA-2:0], 1'b0};
          end
          if (edge_last) state_d = S_STORE;
        end
      end

      S_STORE: begin
        if (!(op_q && full)) begin
          if (op_q) begin
            wr_d    = 1'b1;
            wdata_d = rx_sr_q;
          end
          words_d = words_q - LEN_W'(1);
          if (words_q == LEN_W'(1)) begin
            tmr_d   = div_q;
            state_d = S_FINISH;
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      S_FINISH: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - DIV_W'(1);
        end else begin
          scsn_d  = '1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          mosi_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= 1'b0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      div_q      <= '0;
      tmr_q      <= '0;
      cs_q       <= '0;
      words_q    <= '0;
      ecnt_q     <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      wdata_q    <= '0;
      fetch_ph_q <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      scsn_q     <= '1;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      div_q      <= div_d;
      tmr_q      <= tmr_d;
      cs_q       <= cs_d;
      words_q    <= words_d;
      ecnt_q     <= ecnt_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      wdata_q    <= wdata_d;
      fetch_ph_q <= fetch_ph_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      scsn_q     <= scsn_d;
    end
  end

  assign rd        = rd_q;
  assign wr        = wr_q;
  assign wdata     = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign scsn      = scsn_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed testbench for spi_master_multi with the default parameters
// (DATA=8, CS_NUM=2, DIV_W=8, LEN_W=16).
// A TX FIFO model gives rdata one cycle after rd.
// miso comes either from a loopback of mosi or from a mode-aware SPI slave model.
module tb_spi_master_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       work = 1'b0, op = 1'b0;
  logic [15:0] len = '0;
  logic [7:0] cfg_div = '0;
  logic       cfg_cpol = 1'b0, cfg_cpha = 1'b0;
  logic [0:0] cfg_cs = '0;
  logic [7:0] rdata = '0;
  logic       rd, empty, wr, busy, done, sclk, mosi, miso;
  logic       full = 1'b0;
  logic [7:0] wdata;
  logic [1:0] scsn;
  logic [2:0] dbg_state;

  spi_master_multi dut (
    .clk(clk), .rst(rst), .work(work), .op(op), .len(len), .cfg_div(cfg_div),
    .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_cs(cfg_cs),
    .rdata(rdata), .rd(rd), .empty(empty), .wdata(wdata), .wr(wr), .full(full),
    .busy(busy), .done(done), .sclk(sclk), .mosi(mosi), .miso(miso),
    .scsn(scsn), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- TX FIFO model and bus monitor (negedge) ----------------
  logic [7:0] tx_mem [64];
  int ptr = 0;
  int tx_lim = 0;
  assign empty = (ptr >= tx_lim);

  int cyc = 0, rd_total = 0, wr_total = 0, done_total = 0;
  int toggle_total = 0, rise_total = 0, cs0_fall = 0, cs1_fall = 0;
  int cs0_low = 0, cs1_low = 0;
  int rise_log [64];
  logic [7:0] rx_log [256];
  logic sclk_prev = 1'b0;
  logic [1:0] scsn_prev = 2'b11;

  always @(negedge clk) begin
    cyc++;
    if (rd === 1'b1) begin
      rdata = tx_mem[ptr & 63];
      ptr++;
      rd_total++;
    end
    if (wr === 1'b1) begin
      rx_log[wr_total & 255] = wdata;
      wr_total++;
    end
    if (done === 1'b1) done_total++;
    if (sclk !== sclk_prev) begin
      toggle_total++;
      if (sclk === 1'b1) begin
        rise_log[rise_total & 63] = cyc;
        rise_total++;
      end
    end
    sclk_prev = sclk;
    if (scsn[0] === 1'b0 && scsn_prev[0] === 1'b1) cs0_fall++;
    if (scsn[1] === 1'b0 && scsn_prev[1] === 1'b1) cs1_fall++;
    if (scsn[0] === 1'b0) cs0_low++;
    if (scsn[1] === 1'b0) cs1_low++;
    scsn_prev = scsn;
  end

  // ---------------- SPI slave model on scsn[0] ----------------
  logic loopback = 1'b1;
  logic m_cpol = 1'b0, m_cpha = 1'b0;
  logic [7:0] sdata [4];
  logic [7:0] s_rx = '0;
  logic [7:0] s_rx_log [64];
  logic s_miso = 1'b0;
  int s_bit = 0, s_word = 0, s_rx_cnt = 0;
  logic s_cs_prev = 1'b1, s_sclk_prev = 1'b0;
  logic [7:0] s_cur;
  assign miso = loopback ? mosi : s_miso;

  always @(sclk or scsn) begin
    if (scsn[0] === 1'b0 && s_cs_prev === 1'b1) begin
      s_bit = 0;
      s_word = 0;
      s_rx = '0;
      s_cur = sdata[0];
      s_miso = m_cpha ? 1'b0 : s_cur[7];
    end else if (scsn[0] === 1'b0 && sclk !== s_sclk_prev) begin
      if (sclk !== m_cpol) begin
        // leading edge
        if (!m_cpha) begin
          s_rx = {s_rx[6:0], mosi};
        end else begin
          s_cur = sdata[s_word & 3];
          s_miso = s_cur[7 - s_bit];
        end
      end else begin
        // trailing edge
        if (m_cpha) s_rx = {s_rx[6:0], mosi};
        s_bit++;
        if (s_bit == 8) begin
          s_rx_log[s_rx_cnt & 63] = s_rx;
          s_rx_cnt++;
          s_word++;
          s_bit = 0;
        end
        if (!m_cpha) begin
          s_cur = sdata[s_word & 3];
          s_miso = s_cur[7 - s_bit];
        end
      end
    end
    s_cs_prev = scsn[0];
    s_sclk_prev = sclk;
  end

  // ---------------- driver tasks ----------------
  task automatic load_tx(input int idx, input logic [7:0] v);
    tx_mem[(ptr + idx) & 63] = v;
  endtask

  task automatic start_burst(input logic o, input int n, input int d,
                             input logic pol, input logic pha, input int cs);
    @(negedge clk);
    op = o; len = 16'(n); cfg_div = 8'(d); cfg_cpol = pol; cfg_cpha = pha;
    cfg_cs = 1'(cs); work = 1'b1;
    @(negedge clk);
    work = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, input string name);
    int k = 0;
    while (done_total == d0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if (done_total == d0) begin
      n_fail++;
      $display("FAIL %s_timeout: done not seen in %0d cycles", name, budget);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if ({rd, wr, busy, done, mosi, sclk} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 000000", {rd, wr, busy, done, mosi, sclk});
    end
    n_tests++;
    if (scsn !== 2'b11) begin n_fail++; $display("FAIL reset_scsn: got %b want 11", scsn); end
    n_tests++;
    if (wdata !== 8'h00) begin n_fail++; $display("FAIL reset_wdata: got %h want 00", wdata); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (dbg_state !== 3'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: state %0d busy %b want 0 0", dbg_state, busy);
    end
  endtask

  task automatic test_mode0_loop();
    int r0, w0, d0;
    loopback = 1'b1;
    load_tx(0, 8'hA5);
    tx_lim = ptr + 1;
    r0 = rise_total; w0 = wr_total; d0 = done_total;
    start_burst(1'b1, 1, 1, 1'b0, 1'b0, 0);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy: got %b want 1", busy); end
    wait_done(d0, 500, "t1");
    n_tests++;
    if (rise_total - r0 != 8) begin
      n_fail++; $display("FAIL t1_rises: got %0d want 8", rise_total - r0);
    end else begin
      n_tests++;
      if (rise_log[(r0 + 7) & 63] - rise_log[r0 & 63] != 28) begin
        n_fail++;
        $display("FAIL t1_period: 7 periods took %0d want 28",
                 rise_log[(r0 + 7) & 63] - rise_log[r0 & 63]);
      end
    end
    n_tests++;
    if (wr_total - w0 != 1 || rx_log[w0 & 255] !== 8'hA5) begin
      n_fail++;
      $display("FAIL t1_rx: wr %0d data %h want 1 a5", wr_total - w0, rx_log[w0 & 255]);
    end
    n_tests++;
    if (done_total - d0 != 1) begin
      n_fail++; $display("FAIL t1_done: got %0d want 1", done_total - d0);
    end
  endtask

  task automatic test_modes();
    logic [7:0] tx_exp [3];
    tx_exp[0] = 8'h81; tx_exp[1] = 8'h3C; tx_exp[2] = 8'hFF;
    sdata[0] = 8'h5A; sdata[1] = 8'hC3; sdata[2] = 8'h01; sdata[3] = 8'h00;
    for (int m = 0; m < 4; m++) begin
      int w0, d0, s0, f0;
      logic pol, pha;
      pol = m[1]; pha = m[0];
      m_cpol = pol; m_cpha = pha;
      loopback = 1'b0;
      for (int i = 0; i < 3; i++) load_tx(i, tx_exp[i]);
      tx_lim = ptr + 3;
      w0 = wr_total; d0 = done_total; s0 = s_rx_cnt; f0 = cs0_fall;
      start_burst(1'b1, 3, 1, pol, pha, 0);
      wait_done(d0, 1000, "t2");
      n_tests++;
      if (wr_total - w0 != 3 || rx_log[w0 & 255] !== sdata[0] ||
          rx_log[(w0 + 1) & 255] !== sdata[1] || rx_log[(w0 + 2) & 255] !== sdata[2]) begin
        n_fail++;
        $display("FAIL t2_rx mode%0d: wr %0d got %h %h %h want 5a c3 01", m, wr_total - w0,
                 rx_log[w0 & 255], rx_log[(w0 + 1) & 255], rx_log[(w0 + 2) & 255]);
      end
      n_tests++;
      if (s_rx_cnt - s0 != 3 || s_rx_log[s0 & 63] !== 8'h81 ||
          s_rx_log[(s0 + 1) & 63] !== 8'h3C || s_rx_log[(s0 + 2) & 63] !== 8'hFF) begin
        n_fail++;
        $display("FAIL t2_slave mode%0d: cnt %0d got %h %h %h want 81 3c ff", m, s_rx_cnt - s0,
                 s_rx_log[s0 & 63], s_rx_log[(s0 + 1) & 63], s_rx_log[(s0 + 2) & 63]);
      end
      n_tests++;
      if (sclk !== pol) begin n_fail++; $display("FAIL t2_idle mode%0d: sclk %b want %b", m, sclk, pol); end
      n_tests++;
      if (cs0_fall - f0 != 1 || scsn !== 2'b11) begin
        n_fail++;
        $display("FAIL t2_cs mode%0d: falls %0d scsn %b want 1 11", m, cs0_fall - f0, scsn);
      end
    end
    loopback = 1'b1;
  endtask

  task automatic test_write_only_cs1();
    int r0, w0, d0, c0, c1;
    loopback = 1'b1;
    for (int i = 0; i < 4; i++) load_tx(i, 8'(8'h10 + i));
    tx_lim = ptr + 4;
    r0 = rd_total; w0 = wr_total; d0 = done_total; c0 = cs0_low; c1 = cs1_low;
    start_burst(1'b0, 4, 0, 1'b0, 1'b0, 1);
    repeat (8) @(negedge clk);
    n_tests++;
    if (scsn !== 2'b01) begin n_fail++; $display("FAIL t3_scsn: got %b want 01", scsn); end
    wait_done(d0, 1000, "t3");
    n_tests++;
    if (rd_total - r0 != 4 || wr_total - w0 != 0) begin
      n_fail++; $display("FAIL t3_pulses: rd %0d wr %0d want 4 0", rd_total - r0, wr_total - w0);
    end
    n_tests++;
    if (cs0_low != c0 || cs1_low == c1) begin
      n_fail++; $display("FAIL t3_cs_sel: cs0 low %0d cs1 low %0d want 0 >0", cs0_low - c0, cs1_low - c1);
    end
  endtask

  task automatic test_stalls();
    int r0, w0, d0, t0, k;
    loopback = 1'b1;
    load_tx(0, 8'hA1); load_tx(1, 8'hB2); load_tx(2, 8'hC3);
    tx_lim = ptr + 1;
    r0 = rd_total; w0 = wr_total; d0 = done_total;
    start_burst(1'b1, 3, 1, 1'b0, 1'b0, 0);
    k = 0;
    while (wr_total == w0 && k < 500) begin @(negedge clk); k++; end
    n_tests++;
    if (wr_total == w0) begin n_fail++; $display("FAIL t4_word1: wr not seen, got 0 want 1"); end
    t0 = toggle_total;
    repeat (50) @(negedge clk);
    n_tests++;
    if (toggle_total != t0 || scsn !== 2'b10 || rd_total - r0 != 1) begin
      n_fail++;
      $display("FAIL t4_empty_stall: toggles %0d scsn %b rd %0d want 0 10 1",
               toggle_total - t0, scsn, rd_total - r0);
    end
    full = 1'b1;
    tx_lim = tx_lim + 2;
    repeat (80) @(negedge clk);
    n_tests++;
    if (wr_total - w0 != 1 || rd_total - r0 != 2) begin
      n_fail++;
      $display("FAIL t4_full_stall: wr %0d rd %0d want 1 2", wr_total - w0, rd_total - r0);
    end
    full = 1'b0;
    wait_done(d0, 1000, "t4");
    n_tests++;
    if (wr_total - w0 != 3 || rx_log[w0 & 255] !== 8'hA1 ||
        rx_log[(w0 + 1) & 255] !== 8'hB2 || rx_log[(w0 + 2) & 255] !== 8'hC3) begin
      n_fail++;
      $display("FAIL t4_rx: wr %0d got %h %h %h want a1 b2 c3", wr_total - w0,
               rx_log[w0 & 255], rx_log[(w0 + 1) & 255], rx_log[(w0 + 2) & 255]);
    end
  endtask

  task automatic test_len0_and_busy_work();
    int r0, d0;
    r0 = rd_total; d0 = done_total;
    tx_lim = ptr;
    start_burst(1'b1, 0, 1, 1'b0, 1'b0, 0);
    n_tests++;
    if (done !== 1'b1 || scsn !== 2'b11 || busy !== 1'b0) begin
      n_fail++; $display("FAIL t5_len0: done %b scsn %b busy %b want 1 11 0", done, scsn, busy);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || rd_total != r0) begin
      n_fail++; $display("FAIL t5_len0_after: done %b rd %0d want 0 0", done, rd_total - r0);
    end
    // A second work while busy must be ignored.
    load_tx(0, 8'h77); load_tx(1, 8'h66);
    tx_lim = ptr + 2;
    r0 = rd_total; d0 = done_total;
    start_burst(1'b1, 1, 1, 1'b0, 1'b0, 0);
    repeat (5) @(negedge clk);
    len = 16'd4; work = 1'b1;
    @(negedge clk);
    work = 1'b0;
    wait_done(d0, 500, "t5");
    repeat (20) @(negedge clk);
    n_tests++;
    if (done_total - d0 != 1 || rd_total - r0 != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_busy_work: done %0d rd %0d busy %b want 1 1 0", done_total - d0, rd_total - r0, busy);
    end
    tx_lim = ptr;
  endtask

  task automatic test_reset_mid_burst();
    int t0, k, w0, d0;
    loopback = 1'b1;
    load_tx(0, 8'hE7); load_tx(1, 8'h18);
    tx_lim = ptr + 2;
    t0 = toggle_total;
    start_burst(1'b1, 2, 3, 1'b0, 1'b0, 0);
    k = 0;
    while (toggle_total - t0 < 5 && k < 500) begin @(negedge clk); k++; end
    d0 = done_total;
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (scsn !== 2'b11 || sclk !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL t6_async: scsn %b sclk %b busy %b want 11 0 0", scsn, sclk, busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tx_lim = ptr;
    load_tx(0, 8'h3C);
    tx_lim = ptr + 1;
    w0 = wr_total;
    n_tests++;
    if (done_total != d0) begin n_fail++; $display("FAIL t6_no_done: got %0d want 0", done_total - d0); end
    start_burst(1'b1, 1, 1, 1'b0, 1'b0, 0);
    wait_done(d0, 500, "t6");
    n_tests++;
    if (wr_total - w0 != 1 || rx_log[w0 & 255] !== 8'h3C) begin
      n_fail++; $display("FAIL t6_clean: wr %0d data %h want 1 3c", wr_total - w0, rx_log[w0 & 255]);
    end
  endtask

  initial begin
    test_reset();
    test_mode0_loop();
    test_modes();
    test_write_only_cs1();
    test_stalls();
    test_len0_and_busy_work();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
